// File: rtl/iir_out_capture_if.sv
// iir_out_capture_if: start/latency control, sample stream, buffer readback and block statistics
interface iir_out_capture_if #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int LW = 6,
   parameter int SW = DW + AW
);
   logic          start;
   logic [LW-1:0] lat_cfg;
   logic [DW-1:0] in_data;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          busy;
   logic          data_valid;
   logic [AW:0]   wr_count;
   logic [DW-1:0] peak_max;
   logic [DW-1:0] peak_min;
   logic [SW-1:0] sum;
   modport master (
      output start, lat_cfg, in_data, rd_addr,
      input  rd_data, busy, data_valid, wr_count, peak_max, peak_min, sum
   );
   modport slave (
      input  start, lat_cfg, in_data, rd_addr,
      output rd_data, busy, data_valid, wr_count, peak_max, peak_min, sum
   );
endinterface

// File: rtl/iir_out_capture.sv
// iir_out_capture: waits lat_cfg cycles after a start edge, captures DEPTH samples and their max/min/sum
module iir_out_capture #(
   parameter int DW    = 32,
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int LW    = 6,
   parameter int SW    = DW + AW
) (
   input logic              clk,
   input logic              reset,
   iir_out_capture_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, CAPT = 2'd2, DONE = 2'd3;
   localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);
   logic [1:0]    state;
   logic          start_r;
   logic [LW-1:0] lat;
   logic [AW:0]   cnt;
   logic          valid;
   logic [DW-1:0] max_r, min_r;
   logic [SW-1:0] sum_r;
   logic [DW-1:0] buffer [DEPTH];
   logic          start_edge, first, cap;
   logic [SW-1:0] sx;
   assign start_edge = bus.start & ~start_r;
   assign first      = state == WAIT && lat == '0;
   assign cap        = first || state == CAPT;
   assign sx         = {{(SW - DW){bus.in_data[DW-1]}}, bus.in_data};
   assign bus.rd_data    = int'(bus.rd_addr) < DEPTH ? buffer[bus.rd_addr] : '0;
   assign bus.busy       = state == WAIT || state == CAPT;
   assign bus.data_valid = valid;
   assign bus.wr_count   = cnt;
   assign bus.peak_max   = max_r;
   assign bus.peak_min   = min_r;
   assign bus.sum        = sum_r;
   // buffer is deliberately left out of reset; an aborting start edge writes nothing
   always_ff @(posedge clk)
      if (reset && !start_edge && cap) buffer[cnt[AW-1:0]] <= bus.in_data;
   always_ff @(posedge clk)
      if (!reset) begin
         state   <= IDLE;
         start_r <= 1'b0;
         lat     <= '0;
         cnt     <= '0;
         valid   <= 1'b0;
         max_r   <= '0;
         min_r   <= '0;
         sum_r   <= '0;
      end else begin
         start_r <= bus.start;
         if (start_edge) begin
            state <= WAIT;
            lat   <= bus.lat_cfg;
            cnt   <= '0;
            valid <= 1'b0;
            max_r <= '0;
            min_r <= '0;
            sum_r <= '0;
         end else if (cap) begin
            cnt   <= cnt + 1'b1;
            max_r <= (first || $signed(bus.in_data) > $signed(max_r)) ? bus.in_data : max_r;
            min_r <= (first || $signed(bus.in_data) < $signed(min_r)) ? bus.in_data : min_r;
            sum_r <= (first ? '0 : sum_r) + sx;
            state <= cnt == LAST ? DONE : CAPT;
            valid <= cnt == LAST;
         end else if (state == WAIT) begin
            lat <= lat - 1'b1;
         end
      end
endmodule

// File: tb/tb_iir_out_capture.sv
// tb_iir_out_capture: directed vectors for alignment, signed statistics, restart and reset handling
module tb_iir_out_capture;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   iir_out_capture_if #(.DW(32), .AW(5), .LW(6), .SW(37)) bus ();
   iir_out_capture #(.DW(32), .DEPTH(32), .AW(5), .LW(6), .SW(37)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   typedef struct {
      logic [5:0]  lat;
      logic [31:0] a, b, mx, mn;
      logic [36:0] s;
   } vec_t;
   vec_t vt [5];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic blk(input logic [5:0] lat, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b0;
      tick();
      bus.start   = 1'b1;
      bus.lat_cfg = lat;
      bus.in_data = 32'hDEAD_BEEF;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < lat; i++) begin
         bus.in_data = 32'hDEAD_0000 + i;
         tick();
      end
      for (int k = 0; k < 32; k++) begin
         bus.in_data = k[0] ? b : a;
         if (k == 31) chk("valid_before_last", 64'(bus.data_valid), 64'd0);
         tick();
      end
   endtask
   initial begin
      vt[0] = '{lat: 6'd0, a: 32'hFFFF_FFFB, b: 32'd7, mx: 32'd7, mn: 32'hFFFF_FFFB, s: 37'd32};
      vt[1] = '{lat: 6'd3, a: 32'h8000_0000, b: 32'h8000_0000, mx: 32'h8000_0000, mn: 32'h8000_0000, s: 37'h10_0000_0000};
      vt[2] = '{lat: 6'd1, a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, mx: 32'h7FFF_FFFF, mn: 32'h7FFF_FFFF, s: 37'h0F_FFFF_FFE0};
      vt[3] = '{lat: 6'd5, a: 32'd10, b: 32'd3, mx: 32'd10, mn: 32'd3, s: 37'd208};
      vt[4] = '{lat: 6'd2, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFE, mx: 32'hFFFF_FFFF, mn: 32'hFFFF_FFFE, s: 37'h1F_FFFF_FFD0};
      bus.start   = 1'b0;
      bus.lat_cfg = '0;
      bus.in_data = '0;
      bus.rd_addr = '0;
      for (int i = 0; i < 3; i++) begin
         bus.in_data = $urandom;
         tick();
      end
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_valid", 64'(bus.data_valid), 64'd0);
      chk("rst_wr_count", 64'(bus.wr_count), 64'd0);
      chk("rst_max", 64'(bus.peak_max), 64'd0);
      chk("rst_min", 64'(bus.peak_min), 64'd0);
      chk("rst_sum", 64'(bus.sum), 64'd0);
      reset = 1'b1;
      bus.lat_cfg = 6'd8;
      for (int e = 1; e <= 141; e++) begin
         bus.in_data = e;
         bus.start   = e >= 100;
         tick();
         if (e == 99) chk("lat_busy_e99", 64'(bus.busy), 64'd0);
         if (e == 100) chk("lat_busy_e100", 64'(bus.busy), 64'd1);
         if (e == 139) chk("lat_busy_e139", 64'(bus.busy), 64'd1);
         if (e == 139) chk("lat_valid_e139", 64'(bus.data_valid), 64'd0);
         if (e == 140) chk("lat_busy_e140", 64'(bus.busy), 64'd0);
         if (e == 140) chk("lat_valid_e140", 64'(bus.data_valid), 64'd1);
      end
      chk("lat_sum", 64'(bus.sum), 64'd3984);
      chk("lat_max", 64'(bus.peak_max), 64'd140);
      chk("lat_min", 64'(bus.peak_min), 64'd109);
      chk("lat_wr_count", 64'(bus.wr_count), 64'd32);
      for (int k = 0; k < 32; k++) begin
         bus.rd_addr = 5'(k);
         #1;
         chk("lat_buf", 64'(bus.rd_data), 64'(109 + k));
      end
      for (int i = 0; i < 5; i++) begin
         blk(vt[i].lat, vt[i].a, vt[i].b);
         chk("vec_valid", 64'(bus.data_valid), 64'd1);
         chk("vec_busy", 64'(bus.busy), 64'd0);
         chk("vec_max", 64'(bus.peak_max), 64'(vt[i].mx));
         chk("vec_min", 64'(bus.peak_min), 64'(vt[i].mn));
         chk("vec_sum", 64'(bus.sum), 64'(vt[i].s));
         bus.rd_addr = 5'd0;
         #1;
         chk("vec_buf0", 64'(bus.rd_data), 64'(vt[i].a));
         bus.rd_addr = 5'd31;
         #1;
         chk("vec_buf31", 64'(bus.rd_data), 64'(vt[i].b));
      end
      bus.start   = 1'b0;
      tick();
      bus.start   = 1'b1;
      bus.lat_cfg = 6'd0;
      tick();
      chk("rs_valid_clear", 64'(bus.data_valid), 64'd0);
      bus.start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         bus.in_data = 1000 + k;
         tick();
      end
      chk("rs_count10", 64'(bus.wr_count), 64'd10);
      bus.start   = 1'b1;
      bus.lat_cfg = 6'd2;
      bus.in_data = 32'hBAD0_0000;
      tick();
      chk("rs_count0", 64'(bus.wr_count), 64'd0);
      chk("rs_valid0", 64'(bus.data_valid), 64'd0);
      chk("rs_busy", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_data = 32'hBAD0_0001 + i;
         tick();
      end
      for (int k = 0; k < 32; k++) begin
         bus.in_data = 2000 + k;
         tick();
      end
      chk("rs_valid", 64'(bus.data_valid), 64'd1);
      chk("rs_sum", 64'(bus.sum), 64'd64496);
      chk("rs_max", 64'(bus.peak_max), 64'd2031);
      chk("rs_min", 64'(bus.peak_min), 64'd2000);
      for (int k = 0; k < 32; k += 5) begin
         bus.rd_addr = 5'(k);
         #1;
         chk("rs_buf", 64'(bus.rd_data), 64'(2000 + k));
      end
      bus.start   = 1'b1;
      bus.lat_cfg = 6'd0;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.in_data = 500 + k;
         tick();
      end
      reset     = 1'b0;
      bus.start = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("mr_busy", 64'(bus.busy), 64'd0);
      chk("mr_count", 64'(bus.wr_count), 64'd0);
      chk("mr_sum", 64'(bus.sum), 64'd0);
      reset       = 1'b1;
      bus.in_data = 32'hBAD0_0009;
      tick();
      chk("mr_start_busy", 64'(bus.busy), 64'd1);
      for (int k = 0; k < 32; k++) begin
         bus.in_data = 3000 + k;
         tick();
      end
      chk("mr_valid", 64'(bus.data_valid), 64'd1);
      chk("mr_sum_done", 64'(bus.sum), 64'd96496);
      for (int i = 0; i < 5; i++) begin
         bus.in_data = 32'hFFFF_0000;
         tick();
      end
      chk("hold_valid", 64'(bus.data_valid), 64'd1);
      chk("hold_busy", 64'(bus.busy), 64'd0);
      chk("hold_count", 64'(bus.wr_count), 64'd32);
      chk("hold_sum", 64'(bus.sum), 64'd96496);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
